// File: rtl/power_domain_sequencer.sv
// rtl/power_domain_sequencer.sv - Moore sequencer for isolation, clock, reset and switch of one power domain.
// Define PWR_SEQ_TIMEOUT_EN to enable the switch-acknowledge timeout and the FAULT state.
module power_domain_sequencer #(
  parameter int ACK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_on_i,
  output logic req_ready_o,
  output logic done_o,
  output logic is_on_o,
  output logic fault_o,
  output logic switch_no,
  input  logic switch_ack_ni,
  output logic iso_no,
  output logic rst_no,
  output logic clkgate_en_no
);

  typedef enum logic [3:0] {
    INIT, ON, PD_ISO, PD_CLK, PD_RST, PD_SW, OFF,
    PU_SW, PU_SETTLE, PU_CLK, PU_RST, PU_ISO, FAULT
  } state_t;

`ifdef PWR_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sw_q, sw_d, iso_q, iso_d, rstn_q, rstn_d, clk_q, clk_d;
  logic        ready_q, ready_d, done_q, done_d, on_q, on_d, fault_q, fault_d;
  logic        accept, timeout_hit;

  assign accept      = req_valid_i & ready_q;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == ACK_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:      state_d = ON;
      ON:        if (accept && !req_on_i) state_d = PD_ISO;
      PD_ISO:    state_d = PD_CLK;
      PD_CLK:    state_d = PD_RST;
      PD_RST:    state_d = PD_SW;
      PD_SW:     if (switch_ack_ni) state_d = OFF;
                 else if (timeout_hit) state_d = FAULT;
      OFF:       if (accept && req_on_i) state_d = PU_SW;
      PU_SW:     if (!switch_ack_ni) state_d = PU_SETTLE;
                 else if (timeout_hit) state_d = FAULT;
      PU_SETTLE: if (cnt_q == SETTLE_LAST) state_d = PU_CLK;
      PU_CLK:    state_d = PU_RST;
      PU_RST:    state_d = PU_ISO;
      PU_ISO:    state_d = ON;
      FAULT:     if (accept) state_d = req_on_i ? PU_SW : PD_ISO;
      default:   state_d = INIT;
    endcase
  end

  // Outputs are registered from the next state, so they always match the current state's decode.
  always_comb begin
    sw_d    = sw_q;
    iso_d   = iso_q;
    rstn_d  = rstn_q;
    clk_d   = clk_q;
    ready_d = 1'b0;
    on_d    = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ON:                { sw_d, iso_d, rstn_d, clk_d } = 4'b0111;
      PD_ISO:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0011;
      PD_CLK:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0010;
      PD_RST:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0000;
      PD_SW, OFF:        { sw_d, iso_d, rstn_d, clk_d } = 4'b1000;
      PU_SW, PU_SETTLE:  { sw_d, iso_d, rstn_d, clk_d } = 4'b0000;
      PU_CLK:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0001;
      PU_RST:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0011;
      PU_ISO:            { sw_d, iso_d, rstn_d, clk_d } = 4'b0111;
      FAULT:             fault_d = TIMEOUT_EN;
      default:           { sw_d, iso_d, rstn_d, clk_d } = 4'b0000;
    endcase
    if (state_d == ON || state_d == OFF || state_d == FAULT) ready_d = 1'b1;
    if (state_d == ON) on_d = 1'b1;
    done_d = (state_q == PU_ISO && state_d == ON) ||
             (state_q == PD_SW && state_d == OFF) ||
             (accept && state_q == ON && req_on_i) ||
             (accept && state_q == OFF && !req_on_i);
    cnt_d = (state_d != state_q) ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= 16'd0;
      sw_q    <= 1'b0;
      iso_q   <= 1'b0;
      rstn_q  <= 1'b0;
      clk_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      iso_q   <= iso_d;
      rstn_q  <= rstn_d;
      clk_q   <= clk_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      on_q    <= on_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign done_o        = done_q;
  assign is_on_o       = on_q;
  assign fault_o       = fault_q;
  assign switch_no     = sw_q;
  assign iso_no        = iso_q;
  assign rst_no        = rstn_q;
  assign clkgate_en_no = clk_q;

endmodule
